core_mem_responder: RTL and testbench
=====================================

Name: core_mem_responder

Overview:
- Memory-side responder for the core's instruction and data buses: completes ibus_req_t / dbus_req_t transactions and returns ibus_resp_t / dbus_resp_t.
- Backed by an internal word array with configurable access latency.
- Round-robin arbiter serialises the two ports onto the single array.
- Stands in for the memory system in core-level simulation, and serves as the reference responder when verifying the core's bus handshakes.

Parameters:
- MEM_WORDS, 8192, number of 64-bit words in the backing array; must be a power of 2.
- LATENCY, 2, cycles from acceptance (addr_ok) to data_ok; legal range 1..15.
- BASE_ADDR, PCINIT, byte address of array word 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset: state clears on a rising clk edge while reset==0.
- ireq  input  ibus_req_t  instruction request: valid, addr.
- iresp  output  ibus_resp_t  instruction response: addr_ok, data_ok, data (32-bit instruction).
- dreq  input  dbus_req_t  data request: valid, addr, size, strobe, data.
- dresp  output  dbus_resp_t  data response: addr_ok, data_ok, data (64-bit).

Behaviour:
- Reset values:
  - all iresp/dresp fields 0.
  - FSM = IDLE, latency counter = 0, last_grant = DBUS (so ibus wins the first tie).
  - The array is not reset; contents persist across reset.
- FSM states:
  - IDLE:
    - If either valid is high, grant one port.
    - Assert that port's addr_ok combinationally in the same cycle.
    - Latch port id, addr, strobe and wdata.
    - Load counter with LATENCY-1 and go to BUSY.
    - addr_ok is never asserted for the non-granted port.
  - BUSY: decrement the counter each cycle; when the counter is 0, go to RESP.
  - RESP:
    - Assert data_ok for exactly one cycle on the granted port; return to IDLE next cycle.
    - Net timing: addr_ok in cycle t, data_ok in cycle t+LATENCY.
    - For LATENCY==1, skip BUSY: IDLE goes directly to RESP.
- Arbitration:
  - Both valid in IDLE: grant the port not granted last.
  - One valid: grant it.
  - Update last_grant on every grant.
- A new request is accepted only in IDLE. No back-to-back acceptance in the RESP cycle, so minimum spacing between addr_ok pulses on the same port is LATENCY+1 cycles.
- Address map:
  - idx = (addr - BASE_ADDR) >> 3, using the low log2(MEM_WORDS) bits.
  - An address is in range iff addr >= BASE_ADDR and idx < MEM_WORDS, computed at full 64-bit width.
  - Out-of-range reads return 0. Out-of-range writes are dropped. Both still complete with the normal handshake.
- Reads:
  - ibus: data = addr[2] ? word[63:32] : word[31:0].
  - dbus read (strobe==0): full 64-bit word.
  - The array is read in the RESP cycle, so a dbus write completed earlier is visible.
- Writes (dbus, strobe!=0):
  - Byte i of the word is updated iff strobe[i].
  - The commit happens at the clock edge ending the RESP cycle.
  - dresp.data is 0 during the write data_ok.
  - size is not checked; strobe is authoritative.
- Requester contract:
  - The requester holds valid and payload stable until data_ok.
  - Payload is latched at acceptance; later changes are ignored.
  - If valid drops mid-transaction, the transaction still completes: data_ok pulses and the write commits.
- Reset mid-transaction:
  - Abort; data_ok is never issued; a pending write does not commit.
  - The outstanding request is not remembered after reset.
- A data_ok cycle may coincide with a new valid on either port; the new request is granted in the following IDLE cycle.

Decomposition:
- Shared package common: existing ibus_req_t/ibus_resp_t/dbus_req_t/dbus_resp_t, PCINIT.
- Add to common:
  - mem_port_t enum {IBUS, DBUS}.
  - mem_rsp_state_t enum {IDLE, BUSY, RESP}.
  - strb_t.
- One natural sub-module: mem_strobe_merge, a combinational byte-enable merge of old word, write data and strobe; reused by the future cache.
- The arbiter stays inline.

Test Plan:
- Preload word 0 = 64'h1111_2222_3333_4444; LATENCY=2; ireq.valid=1, addr=BASE_ADDR+4 -> iresp.addr_ok in cycle t, iresp.data_ok in t+2 with data=32'h1111_2222; no dresp activity.
- dreq write addr=BASE_ADDR+8, strobe=8'h0F, data=64'hAAAA_BBBB_CCCC_DDDD over prior 0, then read the same address -> read data=64'h0000_0000_CCCC_DDDD.
- ireq and dreq both valid from cycle 0 and held -> ibus granted first, dbus accepted at cycle 3 (LATENCY+1); alternation continues with no starvation over 10 transactions.
- Read addr=BASE_ADDR-8 and BASE_ADDR+MEM_WORDS*8 -> data_ok with data=0; a write to the same addresses leaves every array word unchanged.
- Write accepted, then reset=0 for one cycle before data_ok -> no data_ok, target word unchanged, all outputs 0 the cycle after reset; a subsequent read returns the old value.
- LATENCY=1: a single dbus read is accepted at t, data_ok at t+1, and a held second request is accepted at t+2.

Source files
------------

// File: rtl/core_mem_responder_pkg.sv
// Shared bus types and responder enums for the core memory system.
// Also holds the reset PC, which is the default base address of the responder's array.
package core_mem_responder_pkg;

    localparam logic [63:0] PCINIT = 64'h0000_0000_8000_0000;

    typedef logic [7:0] strb_t;
    typedef logic [2:0] msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        strb_t       strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic {
        IBUS = 1'b0,
        DBUS = 1'b1
    } mem_port_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_rsp_state_t;

endpackage

// File: rtl/mem_strobe_merge.sv
// Byte-enable merge: each byte of the result comes from wdata when its strobe bit
// is set, otherwise from the old word.
module mem_strobe_merge
    import core_mem_responder_pkg::*;
(
    input  logic [63:0] old_word,
    input  logic [63:0] wdata,
    input  strb_t       strobe,
    output logic [63:0] merged
);

    // Per-byte select between stored and incoming data
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 8; i++) begin
            if (strobe[i]) begin
                merged[i*8 +: 8] = wdata[i*8 +: 8];
            end else begin
                merged[i*8 +: 8] = old_word[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/core_mem_responder.sv
// Memory-side responder serving the core's ibus and dbus from one word array.
// A round-robin arbiter picks one port per transaction; data_ok follows addr_ok by LATENCY cycles.
module core_mem_responder
    import core_mem_responder_pkg::*;
#(
    parameter int          MEM_WORDS = 8192,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = PCINIT
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    localparam int         IDX_W  = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    mem_rsp_state_t state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    mem_port_t      last_grant_q, last_grant_d;
    mem_port_t      port_q, port_d;
    logic [63:0]    addr_q, addr_d;
    strb_t          strobe_q, strobe_d;
    logic [63:0]    wdata_q, wdata_d;

    logic           grant_valid_s;
    mem_port_t      grant_s;
    logic [63:0]    offset_s;
    logic [63:0]    word_off_s;
    logic           in_range_s;
    logic [IDX_W-1:0] idx_s;
    logic [63:0]    rd_word_s;
    logic [63:0]    merged_s;
    logic           commit_s;
    logic           unused_size_s;

    logic [63:0]    mem_q [MEM_WORDS];

    assign unused_size_s = ^dreq.size;

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= DBUS;
            port_q       <= IBUS;
            addr_q       <= 64'd0;
            strobe_q     <= 8'd0;
            wdata_q      <= 64'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            addr_q       <= addr_d;
            strobe_q     <= strobe_d;
            wdata_q      <= wdata_d;
        end
    end

    // Arbitration, payload latch and latency sequencing
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        port_d        = port_q;
        addr_d        = addr_q;
        strobe_d      = strobe_q;
        wdata_d       = wdata_q;
        grant_valid_s = 1'b0;
        grant_s       = IBUS;
        case (state_q)
            IDLE: begin
                if (ireq.valid || dreq.valid) begin
                    grant_valid_s = 1'b1;
                    if (ireq.valid && dreq.valid) begin
                        grant_s = (last_grant_q == DBUS) ? IBUS : DBUS;
                    end else if (ireq.valid) begin
                        grant_s = IBUS;
                    end else begin
                        grant_s = DBUS;
                    end
                    last_grant_d = grant_s;
                    port_d       = grant_s;
                    if (grant_s == IBUS) begin
                        addr_d   = ireq.addr;
                        strobe_d = 8'd0;
                        wdata_d  = 64'd0;
                    end else begin
                        addr_d   = dreq.addr;
                        strobe_d = dreq.strobe;
                        wdata_d  = dreq.data;
                    end
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = LAT_M1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end else begin
                    state_d = BUSY;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Range check is done at full width so addresses below the base or past the end never alias
    assign offset_s   = addr_q - BASE_ADDR;
    assign word_off_s = offset_s >> 3;
    assign in_range_s = (addr_q >= BASE_ADDR) && (word_off_s < 64'(MEM_WORDS));
    assign idx_s      = offset_s[IDX_W+2:3];
    assign rd_word_s  = in_range_s ? mem_q[idx_s] : 64'd0;

    mem_strobe_merge u_merge (
        .old_word (rd_word_s),
        .wdata    (wdata_q),
        .strobe   (strobe_q),
        .merged   (merged_s)
    );

    assign commit_s = reset && (state_q == RESP) && (port_q == DBUS)
                      && (strobe_q != 8'd0) && in_range_s;

    // Backing array write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_q[idx_s] <= merged_s;
        end
    end

    // Handshake and read data; everything held at zero while reset is asserted
    always_comb begin
        iresp = '0;
        dresp = '0;
        if (reset) begin
            if (grant_valid_s && (grant_s == IBUS)) begin
                iresp.addr_ok = 1'b1;
            end else if (grant_valid_s) begin
                dresp.addr_ok = 1'b1;
            end else begin
                iresp.addr_ok = 1'b0;
            end
            if ((state_q == RESP) && (port_q == IBUS)) begin
                iresp.data_ok = 1'b1;
                iresp.data    = addr_q[2] ? rd_word_s[63:32] : rd_word_s[31:0];
            end else if (state_q == RESP) begin
                dresp.data_ok = 1'b1;
                dresp.data    = (strobe_q == 8'd0) ? rd_word_s : 64'd0;
            end else begin
                iresp.data_ok = 1'b0;
            end
        end else begin
            iresp = '0;
        end
    end

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed bench for core_mem_responder: a LATENCY=2 instance for most scenarios
// and a LATENCY=1 instance for the short-latency timing case.
module tb_core_mem_responder;
    import core_mem_responder_pkg::*;

    localparam logic [63:0] BASE = PCINIT;
    localparam int          MW   = 16;
    localparam int          LAT  = 2;

    logic       clk = 1'b0;
    logic       reset;
    ibus_req_t  ireq, ireq1;
    ibus_resp_t iresp, iresp1;
    dbus_req_t  dreq, dreq1;
    dbus_resp_t dresp, dresp1;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] model [MW];

    always #5 clk = ~clk;

    core_mem_responder #(.MEM_WORDS(MW), .LATENCY(LAT), .BASE_ADDR(BASE)) u_dut (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp), .dreq(dreq), .dresp(dresp)
    );

    core_mem_responder #(.MEM_WORDS(MW), .LATENCY(1), .BASE_ADDR(BASE)) u_dut1 (
        .clk(clk), .reset(reset), .ireq(ireq1), .iresp(iresp1), .dreq(dreq1), .dresp(dresp1)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the data_ok cycle.
    task automatic d_txn(input logic [63:0] addr, input logic [7:0] strb,
                         input logic [63:0] wd, output logic [63:0] rd);
        int n;
        int lat;
        dreq.valid  = 1'b1;
        dreq.addr   = addr;
        dreq.size   = 3'd3;
        dreq.strobe = strb;
        dreq.data   = wd;
        #4;
        n = 0;
        while (!dresp.addr_ok && n < 20) begin
            @(posedge clk); #5; n++;
        end
        check_eq("d_addr_ok", 64'(dresp.addr_ok), 64'd1);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #5; lat++;
            if (dresp.data_ok) break;
        end
        check_eq("d_latency", 64'(lat), 64'(LAT));
        rd = dresp.data;
        @(posedge clk); #1;
        dreq.valid = 1'b0;
    endtask

    task automatic i_txn(input logic [63:0] addr, output logic [31:0] rd);
        int   n;
        int   lat;
        logic noise;
        ireq.valid = 1'b1;
        ireq.addr  = addr;
        #4;
        n     = 0;
        noise = 1'b0;
        while (!iresp.addr_ok && n < 20) begin
            @(posedge clk); #5; n++;
        end
        check_eq("i_addr_ok", 64'(iresp.addr_ok), 64'd1);
        noise = noise | dresp.addr_ok | dresp.data_ok;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #5; lat++;
            noise = noise | dresp.addr_ok | dresp.data_ok;
            if (iresp.data_ok) break;
        end
        check_eq("i_latency", 64'(lat), 64'(LAT));
        check_eq("i_dbus_quiet", 64'(noise), 64'd0);
        rd = iresp.data;
        @(posedge clk); #1;
        ireq.valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd64;
        logic [31:0] rd32;
        int          bad;
        int          i_acc;
        int          d_acc;
        int          dok;

        ireq  = '0; dreq  = '0;
        ireq1 = '0; dreq1 = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #5;
        check_eq("rst_iresp", 64'(iresp), 64'd0);
        check_eq("rst_dresp_ok", 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
        check_eq("rst_dresp_data", dresp.data, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Fill the array with known contents
        for (int k = 0; k < MW; k++) begin
            model[k] = 64'hC0DE_0000_0000_0000 | 64'(k);
        end
        model[0] = 64'h1111_2222_3333_4444;
        model[1] = 64'd0;
        for (int k = 0; k < MW; k++) begin
            d_txn(BASE + 64'(k * 8), 8'hFF, model[k], rd64);
            if (k == 0) check_eq("wr_data_zero", rd64, 64'd0);
        end

        i_txn(BASE + 64'd4, rd32);
        check_eq("ibus_hi_word", 64'(rd32), 64'h1111_2222);
        i_txn(BASE, rd32);
        check_eq("ibus_lo_word", 64'(rd32), 64'h3333_4444);

        d_txn(BASE + 64'd8, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, rd64);
        d_txn(BASE + 64'd8, 8'h00, 64'd0, rd64);
        check_eq("strobe_0f", rd64, 64'h0000_0000_CCCC_DDDD);
        d_txn(BASE + 64'd8, 8'hF0, 64'h1234_5678_9ABC_DEF0, rd64);
        d_txn(BASE + 64'd8, 8'h00, 64'd0, rd64);
        check_eq("strobe_f0", rd64, 64'h1234_5678_CCCC_DDDD);
        model[1] = 64'h1234_5678_CCCC_DDDD;

        d_txn(BASE - 64'd8, 8'h00, 64'd0, rd64);
        check_eq("oor_low_read", rd64, 64'd0);
        d_txn(BASE + 64'(MW * 8), 8'h00, 64'd0, rd64);
        check_eq("oor_high_read", rd64, 64'd0);
        d_txn(BASE - 64'd8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, rd64);
        d_txn(BASE + 64'(MW * 8), 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, rd64);
        for (int k = 0; k < MW; k++) begin
            d_txn(BASE + 64'(k * 8), 8'h00, 64'd0, rd64);
            check_eq($sformatf("array_word_%0d", k), rd64, model[k]);
        end

        // Both ports held valid from the first cycle after reset
        reset = 1'b0;
        @(posedge clk); #1;
        reset       = 1'b1;
        ireq.valid  = 1'b1;
        ireq.addr   = BASE;
        dreq.valid  = 1'b1;
        dreq.addr   = BASE + 64'd16;
        dreq.strobe = 8'h00;
        dreq.data   = 64'd0;
        bad = 0; i_acc = 0; d_acc = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            #4;
            if (iresp.addr_ok !== ((cyc % 6) == 0)) bad++;
            if (dresp.addr_ok !== ((cyc % 6) == 3)) bad++;
            if (iresp.data_ok !== ((cyc % 6) == 2)) bad++;
            if (dresp.data_ok !== ((cyc % 6) == 5)) bad++;
            if (iresp.data_ok && iresp.data !== model[0][31:0]) bad++;
            if (dresp.data_ok && dresp.data !== model[2]) bad++;
            if (iresp.addr_ok) i_acc++;
            if (dresp.addr_ok) d_acc++;
            @(posedge clk); #1;
        end
        ireq.valid = 1'b0;
        dreq.valid = 1'b0;
        check_eq("arb_pattern", 64'(bad), 64'd0);
        check_eq("arb_ibus_count", 64'(i_acc), 64'd5);
        check_eq("arb_dbus_count", 64'(d_acc), 64'd5);
        @(posedge clk); #1;

        // Write aborted by reset one cycle before its data_ok
        dreq.valid  = 1'b1;
        dreq.addr   = BASE + 64'd24;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'hDEAD_BEEF_DEAD_BEEF;
        #4;
        check_eq("abort_addr_ok", 64'(dresp.addr_ok), 64'd1);
        @(posedge clk); #1;
        dreq.valid = 1'b0;
        reset      = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #4;
        check_eq("post_rst_iresp", 64'(iresp), 64'd0);
        check_eq("post_rst_dresp_ok", 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
        check_eq("post_rst_dresp_data", dresp.data, 64'd0);
        dok = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(posedge clk); #5;
            if (dresp.data_ok || iresp.data_ok) dok++;
        end
        check_eq("abort_no_data_ok", 64'(dok), 64'd0);
        @(posedge clk); #1;
        d_txn(BASE + 64'd24, 8'h00, 64'd0, rd64);
        check_eq("abort_word_kept", rd64, model[3]);

        // LATENCY=1 instance: held write twice, then a read of the same word
        dreq1.valid  = 1'b1;
        dreq1.addr   = BASE;
        dreq1.size   = 3'd3;
        dreq1.strobe = 8'hFF;
        dreq1.data   = 64'h0F0F_0F0F_F0F0_F0F0;
        bad = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc == 4) dreq1.strobe = 8'h00;
            #4;
            if (dresp1.addr_ok !== ((cyc % 2) == 0)) bad++;
            if (dresp1.data_ok !== ((cyc % 2) == 1)) bad++;
            if (cyc == 1 && dresp1.data !== 64'd0) bad++;
            if (cyc == 5 && dresp1.data !== 64'h0F0F_0F0F_F0F0_F0F0) bad++;
            if (iresp1.addr_ok || iresp1.data_ok) bad++;
            @(posedge clk); #1;
        end
        dreq1.valid = 1'b0;
        check_eq("lat1_pattern", 64'(bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
